// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: steps a bidirectional shift register through N serial shifts and returns its result
module shift_seq_ctrl #(
  parameter int MSB = 8,
  parameter int CW  = $clog2(MSB + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_dir,
  input  logic           cmd_circular,
  input  logic           cmd_carry_in,
  input  logic [CW-1:0]  cmd_count,
  input  logic [MSB-1:0] cmd_data,
  output logic           sr_en,
  output logic           sr_dir,
  output logic           sr_circular,
  output logic           sr_carry_in,
  output logic           sr_d,
  input  logic [MSB-1:0] sr_out,
  input  logic           sr_carry_out,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [MSB-1:0] rsp_data,
  output logic           rsp_carry,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;
  state_t         r_state, w_next;
  logic           r_dir, r_circ, r_cin, r_rsp_carry;
  logic [MSB-1:0] r_data, r_rsp_data, w_sel;
  logic [CW-1:0]  r_cnt, r_idx, w_cnt_sat;
  logic           w_accept, w_last, w_shift;
  assign w_accept  = cmd_valid && r_state == IDLE;
  assign w_cnt_sat = cmd_count > CW'(MSB) ? CW'(MSB) : cmd_count;
  assign w_last    = r_idx == r_cnt - CW'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = cmd_valid ? (w_cnt_sat != '0 ? SHIFT : CAPTURE) : IDLE;
      SHIFT:   w_next = w_last ? CAPTURE : SHIFT;
      CAPTURE: w_next = RESP;
      RESP:    w_next = rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dir       <= 1'b0;
      r_circ      <= 1'b0;
      r_cin       <= 1'b0;
      r_data      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dir  <= cmd_dir;
        r_circ <= cmd_circular;
        r_cin  <= cmd_carry_in;
        r_data <= cmd_data;
        r_cnt  <= w_cnt_sat;
        r_idx  <= '0;
      end else if (r_state == SHIFT) begin
        r_idx <= r_idx + CW'(1);
      end
      if (r_state == CAPTURE) begin
        r_rsp_data  <= sr_out;
        r_rsp_carry <= sr_carry_out;
      end
    end
  end
  // every output is a function of registers only, so cmd_*/rsp_* cannot glitch them
  assign w_shift     = r_state == SHIFT;
  assign w_sel       = MSB'(1) << r_idx;
  assign sr_en       = w_shift;
  assign sr_dir      = w_shift & r_dir;
  assign sr_circular = w_shift & r_circ;
  assign sr_carry_in = w_shift & r_cin;
  assign sr_d        = w_shift & |(r_data & w_sel);
  assign cmd_ready   = r_state == IDLE;
  assign busy        = r_state != IDLE;
  assign rsp_valid   = r_state == RESP;
  assign rsp_data    = r_rsp_data;
  assign rsp_carry   = r_rsp_carry;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed tests of shift_seq_ctrl driving a behavioural bidir shift register
module tb_shift_seq_ctrl;
  localparam int MSB = 8;
  localparam int CW  = 4;
  logic           clk, rstn, cmd_valid, cmd_ready, cmd_dir, cmd_circular, cmd_carry_in;
  logic [CW-1:0]  cmd_count;
  logic [MSB-1:0] cmd_data, sr_out, rsp_data;
  logic           sr_en, sr_dir, sr_circular, sr_carry_in, sr_d, sr_carry_out;
  logic           rsp_valid, rsp_ready, rsp_carry, busy;
  logic           pl_en, m_cout;
  logic [MSB-1:0] pl_val, m_out;
  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.MSB(MSB), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_circular(cmd_circular), .cmd_carry_in(cmd_carry_in),
    .cmd_count(cmd_count), .cmd_data(cmd_data), .sr_en(sr_en), .sr_dir(sr_dir),
    .sr_circular(sr_circular), .sr_carry_in(sr_carry_in), .sr_d(sr_d),
    .sr_out(sr_out), .sr_carry_out(sr_carry_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register: dir=0 shifts toward MSB, dir=1 toward LSB; circular rotates
  assign sr_out       = m_out;
  assign sr_carry_out = m_cout;
  always @(posedge clk) begin
    if (pl_en) begin
      m_out  <= pl_val;
      m_cout <= 1'b0;
    end else if (sr_en) begin
      if (sr_dir) begin
        m_out  <= {sr_circular ? m_out[0] : sr_d, m_out[MSB-1:1]};
        m_cout <= m_out[0];
      end else begin
        m_out  <= {m_out[MSB-2:0], sr_circular ? m_out[MSB-1] : sr_d};
        m_cout <= m_out[MSB-1];
      end
    end
  end

  task automatic preload(input logic [MSB-1:0] v);
    pl_en = 1'b1;
    pl_val = v;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Called in the low clock phase with the DUT idle; returns at the negedge where rsp_valid is seen.
  // lat counts cycles after the accept edge (the cycle just after it is 1).
  task automatic issue_cmd(input logic dir, input logic circ, input logic cin,
                           input logic [CW-1:0] cnt, input logic [MSB-1:0] data,
                           output int steps, output int lat, output logic [15:0] dseq,
                           output int bad_attr, output int bad_d);
    steps = 0;
    dseq = '0;
    bad_attr = 0;
    bad_d = 0;
    cmd_valid = 1'b1;
    cmd_dir = dir;
    cmd_circular = circ;
    cmd_carry_in = cin;
    cmd_count = cnt;
    cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dir = ~dir;
    cmd_circular = ~circ;
    cmd_carry_in = ~cin;
    cmd_count = ~cnt;
    cmd_data = ~data;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (sr_en) begin
        if (steps < 16) dseq[steps] = sr_d;
        if ({sr_dir, sr_circular, sr_carry_in} !== {dir, circ, cin}) bad_attr++;
        steps++;
      end else if (sr_d !== 1'b0) begin
        bad_d++;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int steps, lat, ba, bd;
    logic [15:0] ds;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, sr_en, sr_dir, sr_circular, sr_carry_in, sr_d, rsp_carry} !== 9'b100000000 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: ready/busy/valid/sr/carry=%b data=%h, want 100000000 data=00",
               {cmd_ready, busy, rsp_valid, sr_en, sr_dir, sr_circular, sr_carry_in, sr_d, rsp_carry}, rsp_data);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, busy, rsp_valid, sr_en, sr_dir, sr_circular, sr_carry_in, sr_d} !== 8'b10000000) begin
      errors++;
      $display("FAIL reset_release: outputs=%b want 10000000",
               {cmd_ready, busy, rsp_valid, sr_en, sr_dir, sr_circular, sr_carry_in, sr_d});
    end
    issue_cmd(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF, steps, lat, ds, ba, bd);
    checks++;
    if (lat !== 2 || steps !== 0) begin
      errors++;
      $display("FAIL first_accept: lat=%0d steps=%0d want lat=2 steps=0", lat, steps);
    end
    finish_rsp();
  endtask

  task automatic test_three_step();
    int steps, lat, ba, bd;
    logic [15:0] ds;
    preload(8'h00);
    issue_cmd(1'b0, 1'b0, 1'b1, 4'd3, 8'b0000_0101, steps, lat, ds, ba, bd);
    checks++;
    if (steps !== 3 || ds[2:0] !== 3'b101) begin
      errors++;
      $display("FAIL three_steps: steps=%0d d=%b want 3 and 101", steps, ds[2:0]);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL three_latency: got %0d want 5", lat);
    end
    checks++;
    if (ba !== 0 || bd !== 0) begin
      errors++;
      $display("FAIL three_attr: bad_attr=%0d bad_d=%0d want 0 0", ba, bd);
    end
    checks++;
    if (rsp_data !== 8'h05 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL three_data: got %h/%b want 05/0", rsp_data, rsp_carry);
    end
    finish_rsp();
  endtask

  task automatic test_rotate();
    int steps, lat, ba, bd;
    logic [15:0] ds;
    preload(8'hA5);
    issue_cmd(1'b1, 1'b1, 1'b0, 4'd8, 8'h00, steps, lat, ds, ba, bd);
    checks++;
    if (steps !== 8 || lat !== 10 || ba !== 0) begin
      errors++;
      $display("FAIL rotate_steps: steps=%0d lat=%0d bad_attr=%0d want 8 10 0", steps, lat, ba);
    end
    checks++;
    if (rsp_data !== 8'hA5 || rsp_carry !== 1'b1) begin
      errors++;
      $display("FAIL rotate_data: got %h/%b want a5/1", rsp_data, rsp_carry);
    end
    finish_rsp();
  endtask

  task automatic test_count_zero();
    int steps, lat, ba, bd;
    logic [15:0] ds;
    preload(8'h3C);
    issue_cmd(1'b0, 1'b0, 1'b0, 4'd0, 8'hFF, steps, lat, ds, ba, bd);
    checks++;
    if (steps !== 0 || lat !== 2 || bd !== 0) begin
      errors++;
      $display("FAIL zero_timing: steps=%0d lat=%0d bad_d=%0d want 0 2 0", steps, lat, bd);
    end
    checks++;
    if (rsp_data !== 8'h3C || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL zero_data: got %h/%b want 3c/0", rsp_data, rsp_carry);
    end
    finish_rsp();
  endtask

  task automatic test_saturate();
    int steps, lat, ba, bd;
    logic [15:0] ds;
    preload(8'h00);
    issue_cmd(1'b0, 1'b0, 1'b0, 4'd15, 8'h03, steps, lat, ds, ba, bd);
    checks++;
    if (steps !== 8 || lat !== 10) begin
      errors++;
      $display("FAIL sat_steps: steps=%0d lat=%0d want 8 10", steps, lat);
    end
    checks++;
    if (ds[7:0] !== 8'h03) begin
      errors++;
      $display("FAIL sat_dseq: got %b want 00000011", ds[7:0]);
    end
    checks++;
    if (rsp_data !== 8'hC0 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL sat_data: got %h/%b want c0/0", rsp_data, rsp_carry);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int steps, lat, ba, bd;
    logic [15:0] ds;
    preload(8'h00);
    issue_cmd(1'b0, 1'b0, 1'b0, 4'd1, 8'h01, steps, lat, ds, ba, bd);
    checks++;
    if (lat !== 3 || rsp_data !== 8'h01) begin
      errors++;
      $display("FAIL bp_first: lat=%0d data=%h want 3 01", lat, rsp_data);
    end
    cmd_count = 4'd2;
    cmd_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = i[0];
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, sr_en} !== 3'b100 || rsp_data !== 8'h01) begin
        errors++;
        $display("FAIL bp_hold%0d: valid/ready/en=%b data=%h want 100 01", i, {rsp_valid, cmd_ready, sr_en}, rsp_data);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_release: valid/busy/ready=%b want 001", {rsp_valid, busy, cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    int steps, lat, ba, bd, w;
    logic [15:0] ds;
    preload(8'h00);
    issue_cmd(1'b1, 1'b0, 1'b0, 4'd2, 8'b0000_0010, steps, lat, ds, ba, bd);
    checks++;
    if (lat !== 4 || rsp_data !== 8'h80 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d data=%h carry=%b want 4 80 0", lat, rsp_data, rsp_carry);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir = 1'b0;
    cmd_circular = 1'b0;
    cmd_carry_in = 1'b0;
    cmd_count = 4'd0;
    cmd_data = 8'h00;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({busy, cmd_ready, rsp_valid} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_gap: busy/ready/valid=%b want 010", {busy, cmd_ready, rsp_valid});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({busy, cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: busy/ready=%b want 10", {busy, cmd_ready});
    end
    w = 0;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h80) begin
      errors++;
      $display("FAIL b2b_second: valid=%b data=%h want 1 80", rsp_valid, rsp_data);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int steps, lat, ba, bd, seen;
    logic [15:0] ds;
    preload(8'h00);
    cmd_valid = 1'b1;
    cmd_dir = 1'b0;
    cmd_circular = 1'b0;
    cmd_carry_in = 1'b0;
    cmd_count = 4'd6;
    cmd_data = 8'h3F;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sr_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_running: sr_en=%b want 1", sr_en);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({sr_en, busy, cmd_ready, rsp_valid} !== 4'b0010 || rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_async: en/busy/ready/valid=%b data=%h want 0010 00", {sr_en, busy, cmd_ready, rsp_valid}, rsp_data);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_no_rsp: %0d active cycles want 0", seen);
    end
    preload(8'h00);
    issue_cmd(1'b0, 1'b0, 1'b0, 4'd2, 8'h03, steps, lat, ds, ba, bd);
    checks++;
    if (lat !== 4 || rsp_data !== 8'h03) begin
      errors++;
      $display("FAIL mid_next: lat=%0d data=%h want 4 03", lat, rsp_data);
    end
    finish_rsp();
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_circular = 1'b0;
    cmd_carry_in = 1'b0;
    cmd_count = '0;
    cmd_data = '0;
    rsp_ready = 1'b0;
    pl_en = 1'b0;
    pl_val = '0;
    m_out = '0;
    m_cout = 1'b0;
    test_reset();
    test_three_step();
    test_rotate();
    test_count_zero();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: MSB, default 8, width of the controlled bidir_shift_reg and of all data buses.
REQ-002 Parameter: CW, default $clog2(MSB+1) (4), width of the shift-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset; asynchronous and active-low.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_dir  input  1  shift direction, passed unchanged to the register's dir.
REQ-008 cmd_circular  input  1  circular mode, passed unchanged to the register's circular.
REQ-009 cmd_carry_in  input  1  carry value, passed unchanged to the register's carry_in.
REQ-010 cmd_count  input  CW  number of shift steps requested.
REQ-011 cmd_data  input  MSB  serial source bits; bit k drives d on step k (LSB first).
REQ-012 sr_en, sr_dir, sr_circular, sr_carry_in, sr_d  output  1 each  drive the shift register's en, dir, circular, carry_in and d.
REQ-013 sr_out  input  MSB  shift register out.
REQ-014 sr_carry_out  input  1  shift register carry_out.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  result consumer ready.
REQ-017 rsp_data  output  MSB  captured sr_out.
REQ-018 rsp_carry  output  1  captured sr_carry_out.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, SHIFT, CAPTURE and RESP.
REQ-021 cmd_ready SHALL equal (state==IDLE); a command is accepted on the rising edge where cmd_valid and cmd_ready are both high.
REQ-022 On accept, the controller SHALL latch dir, circular, carry_in and data, and SHALL latch the count saturated to MSB (values above MSB become MSB).
REQ-023 On accept, the next state SHALL be SHIFT if the latched count is nonzero, else CAPTURE.
REQ-024 In SHIFT, sr_en SHALL be 1 for exactly the latched count cycles.
REQ-025 A step index SHALL start at 0 and increment each SHIFT cycle.
REQ-026 On the edge ending the last step (index = count-1), the state SHALL go to CAPTURE.
REQ-027 sr_d SHALL equal latched data[step index] during SHIFT, and 0 otherwise.
REQ-028 sr_dir, sr_circular and sr_carry_in SHALL hold the latched values for the whole SHIFT state, and SHALL be 0 in IDLE.
REQ-029 sr_en SHALL be 0 in IDLE, CAPTURE and RESP.
REQ-030 In CAPTURE (one cycle), the controller SHALL register sr_out into rsp_data and sr_carry_out into rsp_carry, then go to RESP.
REQ-031 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_carry SHALL stay stable until the rising edge where rsp_ready is high; that edge SHALL return the state to IDLE.
REQ-032 Latency: count N≥1 gives rsp_valid N+2 cycles after the accept edge; count 0 gives it 2 cycles after.
REQ-033 Back-to-back: a new command SHALL be accepted no earlier than the cycle after the RESP handshake, giving one IDLE cycle minimum.
REQ-034 cmd_valid while busy SHALL be ignored with no state change.
REQ-035 rsp_ready while not in RESP SHALL have no effect.
REQ-036 Changes on the cmd_* inputs after accept SHALL NOT affect the command in flight.
REQ-037 All sr_* outputs, rsp_valid, cmd_ready and busy SHALL be decoded from registered state only and SHALL be glitch-free with respect to the cmd_*/rsp_* inputs.

Reset
REQ-038 While rstn is low, the state SHALL be IDLE and all latched fields, the step index and the count SHALL be 0.
REQ-039 Reset values: rsp_data=0, rsp_carry=0, rsp_valid=0, busy=0, cmd_ready=1, all sr_* outputs 0.
REQ-040 Asserting rstn mid-SHIFT SHALL drop sr_en to 0 immediately (asynchronously) and discard the command with no response.
REQ-041 After rstn deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-042 Reset check: release rstn -> cmd_ready=1, busy=0, rsp_valid=0 and all sr_*=0 on the first cycle.
REQ-043 Three-step shift: count=3, data=8'b0000_0101, dir=0, circular=0 -> sr_en high exactly 3 cycles; sr_d=1,0,1; rsp_valid at accept+5; rsp_data equals the bench bidir_shift_reg out at that time.
REQ-044 Circular full rotation: count=8, circular=1, dir=1, register preloaded with 8'hA5 -> sr_en high 8 cycles and rsp_data=8'hA5.
REQ-045 Count boundaries: count=0 -> sr_en never high and rsp_valid at accept+2 with rsp_data equal to the unchanged sr_out; count=15 -> saturated to 8 steps.
REQ-046 Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_data stable; cmd_valid pulses during this time are ignored; rsp_ready=1 -> IDLE next cycle.
REQ-047 Reset mid-operation: assert rstn low on step 2 of a count=6 command -> sr_en=0 immediately; no rsp_valid after release; the next command completes normally.
